clb_logic_block: RTL and testbench

- Single configurable logic block (CLB) tile for the FPGA fabric model.
- Four logic inputs A, B, C, D feed two parameter-programmed function generators, F and G.
- One flip-flop, clocked by K, registers a selected function.
- Two outputs, X and Y, each select either a combinational function or the flip-flop output. Tiles are instantiated in the array by the fabric top level.

---
 rtl/clb_pkg.sv | 16 +
 rtl/clb_lut4.sv | 13 +
 rtl/clb_logic_block.sv | 80 ++++++++
 tb/tb_clb_logic_block.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared encodings and default truth tables for the CLB tile.
package clb_pkg;

    localparam int SEL_COMB   = 0;
    localparam int SEL_REG    = 1;

    localparam int SRC_F      = 0;
    localparam int SRC_G      = 1;

    localparam int MODE_4IN   = 0;
    localparam int MODE_SPLIT = 1;

    localparam logic [15:0] LUT_PARITY4 = 16'h6996;
    localparam logic [15:0] LUT_AND_AB  = 16'h8888;

endpackage

// File: rtl/clb_lut4.sv
// 16-entry truth-table lookup: returns bit idx of the programmed table.
module clb_lut4 #(
    parameter logic [15:0] LUT = 16'h0000
) (
    input  logic [3:0] idx,
    output logic       o
);

    always_comb begin
        o = LUT[idx];
    end

endmodule

// File: rtl/clb_logic_block.sv
// Configurable logic block: two function generators F/G, one flip-flop on K,
// and per-output selection between combinational and registered values.
module clb_logic_block
    import clb_pkg::*;
#(
    parameter logic [15:0] LUT_F   = LUT_PARITY4,
    parameter logic [15:0] LUT_G   = LUT_AND_AB,
    parameter int          MODE    = MODE_4IN,
    parameter int          FF_SRC  = SRC_F,
    parameter int          X_SEL   = SEL_REG,
    parameter int          Y_SEL   = SEL_COMB,
    parameter bit          SR_EN   = 1'b0,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic K,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic X,
    output logic Y
);

    logic [3:0] lut_idx;
    logic       f_raw;
    logic       g_raw;
    logic       f;
    logic       g;
    logic       q_d;
    logic       q_q;

    // Split mode drops D from the index so only the low eight table bits are reachable.
    always_comb begin
        lut_idx = {D, C, B, A};
        if (MODE == MODE_SPLIT) begin
            lut_idx = {1'b0, C, B, A};
        end
    end

    clb_lut4 #(.LUT(LUT_F)) u_lut_f (
        .idx (lut_idx),
        .o   (f_raw)
    );

    clb_lut4 #(.LUT(LUT_G)) u_lut_g (
        .idx (lut_idx),
        .o   (g_raw)
    );

    // In split mode D becomes a 2:1 select between the two 3-input functions.
    always_comb begin
        g = g_raw;
        f = f_raw;
        if ((MODE == MODE_SPLIT) && D) begin
            f = g_raw;
        end
    end

    always_comb begin
        q_d = (FF_SRC == SRC_G) ? g : f;
        if (SR_EN && D) begin
            q_d = 1'b1;
        end
    end

    always_ff @(posedge K) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    always_comb begin
        X = (X_SEL == SEL_REG) ? q_q : f;
        Y = (Y_SEL == SEL_REG) ? q_q : g;
    end

endmodule

// File: tb/tb_clb_logic_block.sv
// Directed checks of CLB tiles in four parameterisations: defaults, split
// mode, synchronous set, and flip-flop fed from G.
module tb_clb_logic_block;

    logic       clk_sys;
    int         checks;
    int         failures;

    // per-instance inputs as {D,C,B,A}
    logic [3:0] in_def, in_spl, in_sr, in_ffg;
    logic       rst_def, rst_spl, rst_sr, rst_ffg;
    logic       x_def, y_def, x_spl, y_spl, x_sr, y_sr, x_ffg, y_ffg;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    clb_logic_block u_def (
        .K(clk_sys), .rst(rst_def),
        .A(in_def[0]), .B(in_def[1]), .C(in_def[2]), .D(in_def[3]),
        .X(x_def), .Y(y_def)
    );

    clb_logic_block #(
        .LUT_F(16'h00E8), .LUT_G(16'h0096), .MODE(1), .X_SEL(0), .Y_SEL(0)
    ) u_spl (
        .K(clk_sys), .rst(rst_spl),
        .A(in_spl[0]), .B(in_spl[1]), .C(in_spl[2]), .D(in_spl[3]),
        .X(x_spl), .Y(y_spl)
    );

    clb_logic_block #(.SR_EN(1'b1), .X_SEL(1)) u_sr (
        .K(clk_sys), .rst(rst_sr),
        .A(in_sr[0]), .B(in_sr[1]), .C(in_sr[2]), .D(in_sr[3]),
        .X(x_sr), .Y(y_sr)
    );

    clb_logic_block #(.FF_SRC(1), .Y_SEL(1)) u_ffg (
        .K(clk_sys), .rst(rst_ffg),
        .A(in_ffg[0]), .B(in_ffg[1]), .C(in_ffg[2]), .D(in_ffg[3]),
        .X(x_ffg), .Y(y_ffg)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    typedef struct {
        logic [3:0] dcba;
        logic       x_exp;
        logic       y_exp;
    } spl_vec_t;

    spl_vec_t spl_vecs[6];

    initial begin
        checks   = 0;
        failures = 0;
        in_def = 4'b0000; in_spl = 4'b0000; in_sr = 4'b0000; in_ffg = 4'b0000;
        rst_def = 1'b1; rst_spl = 1'b1; rst_sr = 1'b1; rst_ffg = 1'b1;

        // defaults: reset, then parity into Q
        in_def = 4'b0100;
        tick();
        chk("def_rst_x", x_def, 1'b0);
        chk("def_rst_y", y_def, 1'b0);
        rst_def = 1'b0;
        tick();
        chk("def_load_par1", x_def, 1'b1);
        in_def = 4'b1111;
        #1;
        chk("def_y_comb", y_def, 1'b1);
        chk("def_x_hold", x_def, 1'b1);
        tick();
        chk("def_load_par0", x_def, 1'b0);
        in_def = 4'b0010;
        tick();
        chk("def_q_one", x_def, 1'b1);
        chk("def_y_a0b1", y_def, 1'b0);
        in_def = 4'b0000;
        #1;
        chk("def_hold_nochg", x_def, 1'b1);
        rst_def = 1'b1;
        in_def  = 4'b0001;
        tick();
        chk("def_mid_rst", x_def, 1'b0);
        chk("def_y_rst_indep", y_def, 1'b0);
        rst_def = 1'b0;
        tick();
        chk("def_resume", x_def, 1'b1);

        // split mode: majority / parity3, D selects G3 onto F
        spl_vecs[0] = '{4'b0011, 1'b1, 1'b0};
        spl_vecs[1] = '{4'b1011, 1'b0, 1'b0};
        spl_vecs[2] = '{4'b1001, 1'b1, 1'b1};
        spl_vecs[3] = '{4'b0001, 1'b0, 1'b1};
        spl_vecs[4] = '{4'b0111, 1'b1, 1'b1};
        spl_vecs[5] = '{4'b1110, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            in_spl = spl_vecs[i].dcba;
            #1;
            chk($sformatf("spl_x_%0d", i), x_spl, spl_vecs[i].x_exp);
            chk($sformatf("spl_y_%0d", i), y_spl, spl_vecs[i].y_exp);
        end

        // synchronous set versus reset and data
        in_sr = 4'b1001;
        tick();
        chk("sr_rst_wins", x_sr, 1'b0);
        rst_sr = 1'b0;
        tick();
        chk("sr_set_wins", x_sr, 1'b1);
        in_sr = 4'b0000;
        tick();
        chk("sr_data_par0", x_sr, 1'b0);
        in_sr  = 4'b1001;
        rst_sr = 1'b1;
        tick();
        chk("sr_rst_over_set", x_sr, 1'b0);

        // flip-flop sourced from G
        tick();
        chk("ffg_rst", y_ffg, 1'b0);
        rst_ffg = 1'b0;
        in_ffg  = 4'b0011;
        tick();
        chk("ffg_load_g1", y_ffg, 1'b1);
        chk("ffg_x_q", x_ffg, 1'b1);
        in_ffg = 4'b0010;
        #1;
        chk("ffg_hold", y_ffg, 1'b1);
        tick();
        chk("ffg_load_g0", y_ffg, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
